// File: rtl/adc_capture_buffer.sv
// Snapshot buffer for paired ADC samples: arm, trigger (software or rising level crossing on ch0),
// then store up to DEPTH {ch1, ch0} pairs in RAM, readable through a 1-cycle synchronous port.
module adc_capture_buffer #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned DATA_W     = 12
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       ad_data_ch0,
    input  logic [DATA_W-1:0]       ad_data_ch1,
    input  logic                    sample_valid,
    input  logic                    arm,
    input  logic                    abort,
    input  logic                    sw_trig,
    input  logic                    trig_en,
    input  logic [DATA_W-1:0]       trig_level,
    input  logic [DEPTH_LOG2:0]     capture_len,
    input  logic                    rd_en,
    input  logic [DEPTH_LOG2-1:0]   rd_addr,
    output logic [2*DATA_W-1:0]     rd_data,
    output logic                    rd_valid,
    output logic [1:0]              state,
    output logic                    busy,
    output logic                    done,
    output logic [DEPTH_LOG2:0]     wr_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    busy_q, done_q;
    logic [CW-1:0]           len_q, len_d;
    logic [CW-1:0]           wr_count_q, wr_count_d;
    logic                    trig_pending_q, trig_pending_d;
    logic                    prev_valid_q, prev_valid_d;
    logic [DATA_W-1:0]       prev_ch0_q, prev_ch0_d;

    logic [CW-1:0]           eff_len;
    logic [CW-1:0]           wr_count_inc;
    logic                    level_hit;
    logic                    trig_event;
    logic                    wr_en;
    logic [DEPTH_LOG2-1:0]   wr_addr;

    logic [2*DATA_W-1:0]     mem [DEPTH];
    logic [2*DATA_W-1:0]     rd_data_q;
    logic                    rd_valid_q;

    always_comb begin
        eff_len      = ((capture_len == '0) || (capture_len > DEPTH_C)) ? DEPTH_C : capture_len;
        wr_count_inc = wr_count_q + ONE_C;
        level_hit    = trig_en && prev_valid_q && (prev_ch0_q < trig_level) &&
                       (ad_data_ch0 >= trig_level);
        trig_event   = sample_valid && (trig_pending_q || sw_trig || level_hit);

        state_d        = state_q;
        len_d          = len_q;
        wr_count_d     = wr_count_q;
        trig_pending_d = trig_pending_q;
        prev_valid_d   = prev_valid_q;
        prev_ch0_d     = prev_ch0_q;
        wr_en          = 1'b0;
        wr_addr        = wr_count_q[DEPTH_LOG2-1:0];

        // Abort wins over arm and trigger; wr_count is left for software to inspect.
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (arm) begin
                        state_d        = StArmed;
                        len_d          = eff_len;
                        wr_count_d     = '0;
                        trig_pending_d = 1'b0;
                        prev_valid_d   = 1'b0;
                    end
                end
                StArmed: begin
                    if (sample_valid) begin
                        prev_ch0_d   = ad_data_ch0;
                        prev_valid_d = 1'b1;
                    end
                    if (trig_event) begin
                        wr_en      = 1'b1;
                        wr_addr    = '0;
                        wr_count_d = ONE_C;
                        state_d    = (len_q == ONE_C) ? StDone : StCapture;
                    end else if (sw_trig) begin
                        trig_pending_d = 1'b1;
                    end
                end
                StCapture: begin
                    if (sample_valid) begin
                        wr_en      = 1'b1;
                        wr_count_d = wr_count_inc;
                        if (wr_count_inc == len_q) begin
                            state_d = StDone;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // busy/done are registered from the next state so they always agree with state.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            len_q          <= DEPTH_C;
            wr_count_q     <= '0;
            trig_pending_q <= 1'b0;
            prev_valid_q   <= 1'b0;
            prev_ch0_q     <= '0;
        end else begin
            state_q        <= state_d;
            busy_q         <= (state_d == StArmed) || (state_d == StCapture);
            done_q         <= (state_d == StDone);
            len_q          <= len_d;
            wr_count_q     <= wr_count_d;
            trig_pending_q <= trig_pending_d;
            prev_valid_q   <= prev_valid_d;
            prev_ch0_q     <= prev_ch0_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {ad_data_ch1, ad_data_ch0};
        end
    end

    // Read-first: the registered read sees the RAM contents before this edge's write.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= mem[rd_addr];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign state    = state_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed bench for adc_capture_buffer: trigger modes, gaps, length clamp, abort, read-first
// behaviour and asynchronous reset, with hand-computed expected values.
module tb_adc_capture_buffer;

    logic        sys_clk;
    logic        rst_n;
    logic [11:0] ad_data_ch0;
    logic [11:0] ad_data_ch1;
    logic        sample_valid;
    logic        arm;
    logic        abort;
    logic        sw_trig;
    logic        trig_en;
    logic [11:0] trig_level;
    logic [10:0] capture_len;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [23:0] rd_data;
    logic        rd_valid;
    logic [1:0]  state;
    logic        busy;
    logic        done;
    logic [10:0] wr_count;

    int errors = 0;
    int checks = 0;

    adc_capture_buffer #(
        .DEPTH_LOG2 (10),
        .DATA_W     (12)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .ad_data_ch0  (ad_data_ch0),
        .ad_data_ch1  (ad_data_ch1),
        .sample_valid (sample_valid),
        .arm          (arm),
        .abort        (abort),
        .sw_trig      (sw_trig),
        .trig_en      (trig_en),
        .trig_level   (trig_level),
        .capture_len  (capture_len),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .state        (state),
        .busy         (busy),
        .done         (done),
        .wr_count     (wr_count)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic feed(input logic v, input logic [11:0] c0, input logic [11:0] c1);
        sample_valid = v;
        ad_data_ch0  = c0;
        ad_data_ch1  = c1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_arm(input logic [10:0] len);
        capture_len = len;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [9:0] a, input logic [23:0] exp);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
        check_eq({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check_eq(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        logic [6:0] vpat;
        rst_n = 1'b0;
        ad_data_ch0 = '0; ad_data_ch1 = '0; sample_valid = 1'b0;
        arm = 1'b0; abort = 1'b0; sw_trig = 1'b0; trig_en = 1'b0;
        trig_level = '0; capture_len = '0; rd_en = 1'b0; rd_addr = '0;

        #12;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_wr_count", 32'(wr_count), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("idle_state", 32'(state), 32'd0);

        // Length clamp, capture_len = 0 -> 1024 pairs; pattern A.
        do_arm(11'd0);
        check_eq("clamp0_armed", 32'(state), 32'd1);
        check_eq("clamp0_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 1024; k++) begin
            sw_trig = (k == 0);
            feed(1'b1, 12'(k), 12'hC00 ^ 12'(k));
            sw_trig = 1'b0;
        end
        check_eq("clamp0_state", 32'(state), 32'd3);
        check_eq("clamp0_done", 32'(done), 32'd1);
        check_eq("clamp0_busy", 32'(busy), 32'd0);
        check_eq("clamp0_count", 32'(wr_count), 32'd1024);
        for (int k = 0; k < 3; k++) feed(1'b1, 12'hABC, 12'hABC);
        check_eq("done_no_write", 32'(wr_count), 32'd1024);
        read_chk("clamp0_rd0", 10'd0, 24'hC00000);
        read_chk("clamp0_rd1023", 10'd1023, 24'hFFF3FF);

        // Length clamp, capture_len = 0x7FF; pattern B overwrites everything.
        do_arm(11'h7FF);
        check_eq("clamp7ff_cnt_clr", 32'(wr_count), 32'd0);
        for (int k = 0; k < 1024; k++) begin
            sw_trig = (k == 0);
            feed(1'b1, 12'(k), 12'h400 + 12'(k));
            sw_trig = 1'b0;
        end
        check_eq("clamp7ff_state", 32'(state), 32'd3);
        check_eq("clamp7ff_count", 32'(wr_count), 32'd1024);
        read_chk("clamp7ff_rd512", 10'd512, 24'h600200);

        // Software trigger pending while no valid sample, then 8-pair capture.
        do_arm(11'd8);
        sw_trig = 1'b1;
        tick();
        sw_trig = 1'b0;
        check_eq("sw_pending_state", 32'(state), 32'd1);
        check_eq("sw_pending_count", 32'(wr_count), 32'd0);
        for (int i = 0; i < 10; i++) begin
            arm = (i == 3);
            feed(1'b1, 12'h100 + 12'(i), 12'h200 + 12'(i));
            arm = 1'b0;
            if (i == 0) begin
                check_eq("sw_first_state", 32'(state), 32'd2);
                check_eq("sw_first_count", 32'(wr_count), 32'd1);
            end
            if (i == 4) check_eq("sw_arm_ignored", 32'(wr_count), 32'd5);
        end
        check_eq("sw_state", 32'(state), 32'd3);
        check_eq("sw_done", 32'(done), 32'd1);
        check_eq("sw_count", 32'(wr_count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            rd_en   = 1'b1;
            rd_addr = 10'(i);
            tick();
            check_eq("sw_rd_valid", 32'(rd_valid), 32'd1);
            check_eq("sw_rd", 32'(rd_data), 32'({12'h200 + 12'(i), 12'h100 + 12'(i)}));
        end
        rd_en = 1'b0;
        tick();
        check_eq("rd_idle_valid", 32'(rd_valid), 32'd0);
        check_eq("rd_hold", 32'(rd_data), 32'h207107);
        read_chk("sw_addr8_untouched", 10'd8, 24'h408008);

        // Level trigger at 0x800; first sample 0x900 must not trigger.
        trig_en    = 1'b1;
        trig_level = 12'h800;
        do_arm(11'd2);
        feed(1'b1, 12'h900, 12'h0A0);
        check_eq("lvl_first_no_trig", 32'(state), 32'd1);
        feed(1'b1, 12'h7F0, 12'h0A1);
        feed(1'b1, 12'h7F8, 12'h0A2);
        check_eq("lvl_below_no_trig", 32'(state), 32'd1);
        feed(1'b1, 12'h800, 12'h0A3);
        check_eq("lvl_trig_state", 32'(state), 32'd2);
        check_eq("lvl_trig_count", 32'(wr_count), 32'd1);
        feed(1'b1, 12'h808, 12'h0A4);
        check_eq("lvl_done", 32'(done), 32'd1);
        check_eq("lvl_count", 32'(wr_count), 32'd2);
        read_chk("lvl_rd0", 10'd0, 24'h0A3800);
        read_chk("lvl_rd1", 10'd1, 24'h0A4808);
        trig_en = 1'b0;

        // Gapped input, len = 4.
        do_arm(11'd4);
        sw_trig = 1'b1;
        tick();
        sw_trig = 1'b0;
        vpat = 7'b1011001;
        for (int j = 0; j < 7; j++) begin
            feed(vpat[j], 12'h300 + 12'(j), 12'h0F0);
            if (j == 5) begin
                check_eq("gap_state", 32'(state), 32'd2);
                check_eq("gap_count", 32'(wr_count), 32'd3);
            end
        end
        check_eq("gap_done", 32'(done), 32'd1);
        check_eq("gap_final_count", 32'(wr_count), 32'd4);
        read_chk("gap_rd1", 10'd1, 24'h0F0303);
        read_chk("gap_rd2", 10'd2, 24'h0F0304);

        // Abort and arm together during CAPTURE.
        do_arm(11'd8);
        for (int k = 0; k < 3; k++) begin
            sw_trig = (k == 0);
            feed(1'b1, 12'h500 + 12'(k), 12'h050);
            sw_trig = 1'b0;
        end
        check_eq("abort_pre_count", 32'(wr_count), 32'd3);
        abort = 1'b1;
        arm   = 1'b1;
        feed(1'b1, 12'hEEE, 12'hEEE);
        abort = 1'b0;
        arm   = 1'b0;
        check_eq("abort_state", 32'(state), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_count", 32'(wr_count), 32'd3);
        feed(1'b1, 12'hDDD, 12'hDDD);
        feed(1'b1, 12'hDDD, 12'hDDD);
        check_eq("abort_idle_count", 32'(wr_count), 32'd3);
        read_chk("abort_rd2", 10'd2, 24'h050502);
        read_chk("abort_rd3_kept", 10'd3, 24'h0F0306);

        // Same-address read during write returns the old contents.
        do_arm(11'd8);
        for (int k = 0; k < 5; k++) begin
            sw_trig = (k == 0);
            rd_en   = (k >= 3);
            rd_addr = 10'd3;
            feed(1'b1, 12'h700 + 12'(k), 12'h070);
            sw_trig = 1'b0;
            if (k == 3) check_eq("rw_old", 32'(rd_data), 32'h0F0306);
            if (k == 4) check_eq("rw_new", 32'(rd_data), 32'h070703);
        end
        rd_en = 1'b0;
        check_eq("rw_state", 32'(state), 32'd2);

        // Asynchronous reset mid-capture.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_state", 32'(state), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_count", 32'(wr_count), 32'd0);
        check_eq("arst_rd_valid", 32'(rd_valid), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        read_chk("arst_partial", 10'd4, 24'h070704);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_capture_buffer.md
# adc_capture_buffer

Snapshot buffer on the ADC side of the `adc`/`dac` datapath. It records paired 12-bit samples from channels 0 and 1 into on-chip RAM after an arm command and a trigger, which is either software or a rising level crossing on channel 0. The SoC then reads the samples back through a synchronous read port. The capture port writes and the SoC reads.

## Interface
- `DEPTH_LOG2`, 10, log2 of buffer depth. DEPTH = 2^DEPTH_LOG2 sample pairs.
- `DATA_W`, 12, ADC sample width per channel. Samples are unsigned offset-binary as delivered by `adc`.

- `sys_clk`  in  1  single clock for all logic
- `rst_n`  in  1  reset, asynchronous, active-low
- `ad_data_ch0`  in  DATA_W  channel 0 sample
- `ad_data_ch1`  in  DATA_W  channel 1 sample
- `sample_valid`  in  1  qualifies `ad_data_ch*` this cycle
- `arm`  in  1  one-cycle pulse to start a capture sequence
- `abort`  in  1  one-cycle pulse to return to IDLE
- `sw_trig`  in  1  one-cycle software trigger pulse
- `trig_en`  in  1  enables the level trigger on ch0
- `trig_level`  in  DATA_W  level-trigger threshold, unsigned
- `capture_len`  in  DEPTH_LOG2+1  samples to record. 0 or any value > DEPTH means DEPTH.
- `rd_en`  in  1  read request
- `rd_addr`  in  DEPTH_LOG2  read address
- `rd_data`  out  2*DATA_W  `{ch1, ch0}` read data
- `rd_valid`  out  1  `rd_data` is valid this cycle
- `state`  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
- `busy`  out  1  high in ARMED or CAPTURE
- `done`  out  1  high in DONE
- `wr_count`  out  DEPTH_LOG2+1  sample pairs written in the current or last capture

## Operation
- **IDLE / DONE, arm:**
  - Go to ARMED.
  - Latch the effective length `len` from `capture_len`, clamped as above.
  - Clear `wr_count`, `trig_pending` and `prev_valid`.
- **arm in ARMED or CAPTURE:** ignored.
- **abort:** from any state, go to IDLE. Abort has priority over arm and over the trigger in the same cycle. `wr_count` keeps its value.
- **ARMED, pending trigger:** `sw_trig` sets `trig_pending`.
- **ARMED, trigger event:** a trigger event is a cycle with `sample_valid` and one of:
  - `trig_pending`;
  - `sw_trig`;
  - `trig_en && prev_valid && prev_ch0 < trig_level && ad_data_ch0 >= trig_level`.
- **Trigger sample:** the triggering sample pair is written at address 0. Then `wr_count` = 1 and the state goes to CAPTURE. If `len` = 1, the state goes directly to DONE.
- **Previous-sample register:** `prev_ch0` loads on every `sample_valid` in ARMED. `prev_valid` is set by the first such load after arm.
- **CAPTURE:**
  - Each `sample_valid` writes `{ch1, ch0}` at address `wr_count[DEPTH_LOG2-1:0]`, then increments `wr_count`.
  - The write that makes `wr_count == len` moves the state to DONE.
  - No writes happen outside ARMED and CAPTURE.
- **DONE:** holds until arm or abort. The RAM contents are retained.
- **Read port:** active in every state.
  - Read-first: a read of the address being written in the same cycle returns the old contents.
  - Locations not written since power-up return undefined data; the bench must not check them.

## Timing
- **Reset values:** `state` = IDLE, `busy` = 0, `done` = 0, `wr_count` = 0, `rd_valid` = 0, `rd_data` = 0. RAM is not reset.
- **State latency:** state changes are visible the cycle after the causing input. `busy`, `done` and `state` are registered and consistent with each other.
- **Trigger to write:** the trigger sample is written on the trigger cycle edge. `wr_count` reads 1 on the next cycle.
- **Read latency:** 1 cycle. `rd_data` and `rd_valid` are registered. `rd_valid` is the previous cycle's `rd_en`. `rd_data` holds its value when `rd_en` is low.
- **Back-to-back:** one read per cycle.
- **Throughput:** `sample_valid` may be high every cycle with no dropped samples.
- **Async reset mid-capture:** the block returns to IDLE immediately and partial data is left in RAM.

## Test plan
- **Software trigger, full path:** `capture_len` = 8, arm, `sw_trig` while `sample_valid` = 0, then feed ch0 = 0x100+i and ch1 = 0x200+i every cycle. Required: exactly 8 writes; DONE; `wr_count` = 8; reading addresses 0..7 returns `{0x200+i, 0x100+i}` one cycle after each `rd_en`.
- **Level trigger:** `trig_en` = 1, `trig_level` = 0x800, ch0 ramps 0x7F0, 0x7F8, 0x800, 0x808. Required: the capture starts at sample 0x800, and address 0 holds ch0 = 0x800. A first sample of 0x900 right after arm must not trigger, because `prev_valid` is 0.
- **Gapped input:** `sample_valid` toggles 1,0,0,1 with `len` = 4. Required: only qualified samples are stored; DONE after the 4th valid sample.
- **Length clamp:** `capture_len` = 0 and, separately, 0x7FF with `DEPTH_LOG2` = 10. Required: each capture stores 1024 pairs; `wr_count` = 1024.
- **Abort priority:** assert abort and arm in the same cycle during CAPTURE. Required: IDLE next cycle and no further writes. Arm pulsed during CAPTURE alone is ignored.
- **Same-address read/write:** read address 3 in the same cycle it is written. Required: the old value is returned and the new value appears on the following read.
